// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned CNT_W_C       = 32;
    localparam int unsigned DEFAULT_DIV_C = 50;
    localparam int unsigned NUM_CH_C      = 4;

    // Channel-index width: clog2(max(n,2)), so a single channel still gets one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned CH_IDX_W = ch_idx_w(NUM_CH_C);

    typedef logic [CNT_W_C-1:0] div_word_t;

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of the multi-channel divider.
// Optional readback port div_rd exists only when CLK_DIV_READBACK_EN is defined.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_C,
    parameter int unsigned CNT_W  = CNT_W_C
);
    localparam int unsigned DIV_CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0]   en;
    logic                sync;
    logic                div_wr;
    logic [DIV_CH_W-1:0] div_ch;
    logic [CNT_W-1:0]    div_data;
    logic [NUM_CH-1:0]   clkOut;
    logic [NUM_CH-1:0]   tick;
    logic [NUM_CH-1:0]   pending;
`ifdef CLK_DIV_READBACK_EN
    logic [CNT_W-1:0]    div_rd;
`endif

    // Controller side: drives enables, sync and divisor writes.
    modport master (
        output en, sync, div_wr, div_ch, div_data,
        input  clkOut, tick, pending
`ifdef CLK_DIV_READBACK_EN
        , input div_rd
`endif
    );

    // Divider side.
    modport slave (
        input  en, sync, div_wr, div_ch, div_data,
        output clkOut, tick, pending
`ifdef CLK_DIV_READBACK_EN
        , output div_rd
`endif
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisors, pending flag, toggle and tick.
// With CLK_DIV_READBACK_EN defined, the active divisor is exported for readback.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_C,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    output logic             clkOut,
    output logic             tick,
    output logic             pending
`ifdef CLK_DIV_READBACK_EN
    ,
    output logic [CNT_W-1:0] active_div
`endif
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;

    // Count, toggle at terminal count, and swap in the shadow divisor only there.
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            active  <= CNT_W'(DEFAULT_DIV);
            shadow  <= CNT_W'(DEFAULT_DIV);
            clkOut  <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            clkOut  <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (wr) begin
                shadow <= wr_data;
                active <= wr_data;
            end else begin
                active <= shadow;
            end
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt == active) begin
                    cnt     <= '0;
                    clkOut  <= ~clkOut;
                    tick    <= 1'b1;
                    active  <= shadow;
                    pending <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // A write landing on the terminal count keeps pending set for the new value.
            if (wr) begin
                shadow  <= wr_data;
                pending <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_READBACK_EN
    assign active_div = active;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decoder, sync fan-out, channel array.
// Define CLK_DIV_READBACK_EN to add the registered active-divisor readback (div_rd).
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_C,
    parameter int unsigned CNT_W       = CNT_W_C,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clkIn,
    input  logic             reset,
    clk_div_multi_if.slave   bus
);

    logic [NUM_CH-1:0] wr_sel_c;
    logic [NUM_CH-1:0] clk_vec;
    logic [NUM_CH-1:0] tick_vec;
    logic [NUM_CH-1:0] pend_vec;

    // Decode the write strobe; an out-of-range channel matches nothing.
    always_comb begin
        wr_sel_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.div_wr && (32'(bus.div_ch) == i)) begin
                wr_sel_c[i] = 1'b1;
            end
        end
    end

`ifdef CLK_DIV_READBACK_EN
    logic [CNT_W-1:0] act_div [NUM_CH];
    logic [CNT_W-1:0] rd_sel_c;
    logic [CNT_W-1:0] div_rd_q;
`endif

    // One independent channel per output.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clkIn      (clkIn),
            .reset      (reset),
            .en         (bus.en[g]),
            .sync       (bus.sync),
            .wr         (wr_sel_c[g]),
            .wr_data    (bus.div_data),
            .clkOut     (clk_vec[g]),
            .tick       (tick_vec[g]),
            .pending    (pend_vec[g])
`ifdef CLK_DIV_READBACK_EN
            ,
            .active_div (act_div[g])
`endif
        );
    end

    assign bus.clkOut  = clk_vec;
    assign bus.tick    = tick_vec;
    assign bus.pending = pend_vec;

`ifdef CLK_DIV_READBACK_EN
    // Select the addressed channel's active divisor; out-of-range reads as zero.
    always_comb begin
        rd_sel_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(bus.div_ch) == i) begin
                rd_sel_c = act_div[i];
            end
        end
    end

    // Register the readback for one-cycle latency.
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            div_rd_q <= '0;
        end else begin
            div_rd_q <= rd_sel_c;
        end
    end

    assign bus.div_rd = div_rd_q;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (5 channels so an out-of-range index exists).
module tb_clk_div_multi;

    localparam int unsigned NCH = 5;
    localparam int unsigned CW  = 32;

    logic clkIn;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;

    clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clk_div_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (50)
    ) dut (
        .clkIn (clkIn),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    task automatic step();
        @(posedge clkIn);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Reset pulse; cycle 1 is the first rising edge after release.
    task automatic do_reset();
        bus.en = '1; bus.sync = 1'b0; bus.div_wr = 1'b0; bus.div_ch = '0; bus.div_data = '0;
        @(posedge clkIn); #1;
        reset = 1'b0;
        @(posedge clkIn); #1;
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        bus.en = '1; bus.sync = 1'b0; bus.div_wr = 1'b0; bus.div_ch = '0; bus.div_data = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        @(posedge clkIn); #1;
        @(posedge clkIn); #1;
        n_tests++;
        if ({bus.clkOut, bus.tick, bus.pending} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clk=%b tick=%b pend=%b exp all 0", bus.clkOut, bus.tick, bus.pending);
        end
`ifdef CLK_DIV_READBACK_EN
        n_tests++;
        if (bus.div_rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_div_rd: got %0d exp 0", bus.div_rd);
        end
`endif
    endtask

    task automatic test_default();
        do_reset();
        run_to(50);
        n_tests++;
        if (bus.clkOut !== 5'b00000 || bus.tick !== 5'b00000) begin
            n_fail++;
            $display("FAIL default_c50: got clk=%b tick=%b exp 00000/00000", bus.clkOut, bus.tick);
        end
        run_to(51);
        n_tests++;
        if (bus.clkOut !== 5'b11111 || bus.tick !== 5'b11111) begin
            n_fail++;
            $display("FAIL default_c51: got clk=%b tick=%b exp 11111/11111", bus.clkOut, bus.tick);
        end
        run_to(52);
        n_tests++;
        if (bus.clkOut !== 5'b11111 || bus.tick !== 5'b00000) begin
            n_fail++;
            $display("FAIL default_c52: got clk=%b tick=%b exp 11111/00000", bus.clkOut, bus.tick);
        end
        run_to(102);
        n_tests++;
        if (bus.clkOut !== 5'b00000 || bus.tick !== 5'b11111) begin
            n_fail++;
            $display("FAIL default_c102: got clk=%b tick=%b exp 00000/11111", bus.clkOut, bus.tick);
        end
        run_to(153);
        n_tests++;
        if (bus.clkOut !== 5'b11111 || bus.tick !== 5'b11111 || bus.pending !== 5'b00000) begin
            n_fail++;
            $display("FAIL default_c153: got clk=%b tick=%b pend=%b exp 11111/11111/00000", bus.clkOut, bus.tick, bus.pending);
        end
    endtask

    task automatic test_write();
        do_reset();
        run_to(9);
        bus.div_wr = 1'b1; bus.div_ch = 3'd1; bus.div_data = 32'd3;
        run_to(10);
        bus.div_wr = 1'b0;
        n_tests++;
        if (bus.pending !== 5'b00010) begin
            n_fail++;
            $display("FAIL write_pend_c10: got %b exp 00010", bus.pending);
        end
        run_to(50);
        n_tests++;
        if (bus.pending !== 5'b00010 || bus.clkOut !== 5'b00000) begin
            n_fail++;
            $display("FAIL write_c50: got pend=%b clk=%b exp 00010/00000", bus.pending, bus.clkOut);
        end
        run_to(51);
        n_tests++;
        if (bus.pending !== 5'b00000 || bus.clkOut !== 5'b11111) begin
            n_fail++;
            $display("FAIL write_c51: got pend=%b clk=%b exp 00000/11111", bus.pending, bus.clkOut);
        end
        run_to(54);
        n_tests++;
        if (bus.clkOut !== 5'b11111 || bus.tick !== 5'b00000) begin
            n_fail++;
            $display("FAIL write_c54: got clk=%b tick=%b exp 11111/00000", bus.clkOut, bus.tick);
        end
        run_to(55);
        n_tests++;
        if (bus.clkOut !== 5'b11101 || bus.tick !== 5'b00010) begin
            n_fail++;
            $display("FAIL write_c55: got clk=%b tick=%b exp 11101/00010", bus.clkOut, bus.tick);
        end
        run_to(59);
        n_tests++;
        if (bus.clkOut !== 5'b11111 || bus.tick !== 5'b00010) begin
            n_fail++;
            $display("FAIL write_c59: got clk=%b tick=%b exp 11111/00010", bus.clkOut, bus.tick);
        end
        run_to(102);
        n_tests++;
        if (bus.clkOut !== 5'b00010 || bus.tick !== 5'b11101) begin
            n_fail++;
            $display("FAIL write_c102: got clk=%b tick=%b exp 00010/11101", bus.clkOut, bus.tick);
        end
    endtask

    task automatic test_enable();
        logic seen_tick;
        seen_tick = 1'b0;
        do_reset();
        run_to(20);
        bus.en[2] = 1'b0;
        while (cyc < 40) begin
            step();
            if (bus.tick[2] !== 1'b0) seen_tick = 1'b1;
        end
        bus.en[2] = 1'b1;
        n_tests++;
        if (seen_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_no_tick: got tick[2] asserted while disabled, exp none");
        end
        run_to(51);
        n_tests++;
        if (bus.clkOut !== 5'b11011 || bus.tick !== 5'b11011) begin
            n_fail++;
            $display("FAIL enable_c51: got clk=%b tick=%b exp 11011/11011", bus.clkOut, bus.tick);
        end
        run_to(70);
        n_tests++;
        if (bus.clkOut[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_c70: got clk[2]=%b exp 0", bus.clkOut[2]);
        end
        run_to(71);
        n_tests++;
        if (bus.clkOut[2] !== 1'b1 || bus.tick[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_c71: got clk[2]=%b tick[2]=%b exp 1/1", bus.clkOut[2], bus.tick[2]);
        end
        run_to(122);
        n_tests++;
        if (bus.clkOut !== 5'b00000 || bus.tick !== 5'b00100) begin
            n_fail++;
            $display("FAIL enable_c122: got clk=%b tick=%b exp 00000/00100", bus.clkOut, bus.tick);
        end
    endtask

    task automatic test_sync();
        do_reset();
        run_to(5);
        bus.div_wr = 1'b1; bus.div_ch = 3'd0; bus.div_data = 32'd7;
        run_to(6);
        bus.div_ch = 3'd3; bus.div_data = 32'd1;
        run_to(7);
        bus.div_wr = 1'b0;
        n_tests++;
        if (bus.pending !== 5'b01001) begin
            n_fail++;
            $display("FAIL sync_pend_before: got %b exp 01001", bus.pending);
        end
        bus.sync = 1'b1;
        run_to(8);
        bus.sync = 1'b0;
        n_tests++;
        if (bus.pending !== 5'b00000 || bus.clkOut !== 5'b00000 || bus.tick !== 5'b00000) begin
            n_fail++;
            $display("FAIL sync_c8: got pend=%b clk=%b tick=%b exp all 0", bus.pending, bus.clkOut, bus.tick);
        end
        run_to(10);
        n_tests++;
        if (bus.clkOut !== 5'b01000 || bus.tick !== 5'b01000) begin
            n_fail++;
            $display("FAIL sync_c10: got clk=%b tick=%b exp 01000/01000", bus.clkOut, bus.tick);
        end
        run_to(16);
        n_tests++;
        if (bus.clkOut !== 5'b00001 || bus.tick !== 5'b01001) begin
            n_fail++;
            $display("FAIL sync_c16: got clk=%b tick=%b exp 00001/01001", bus.clkOut, bus.tick);
        end
        run_to(24);
        n_tests++;
        if (bus.clkOut !== 5'b00000 || bus.tick !== 5'b01001) begin
            n_fail++;
            $display("FAIL sync_c24: got clk=%b tick=%b exp 00000/01001", bus.clkOut, bus.tick);
        end
        run_to(59);
        n_tests++;
        if (bus.clkOut !== 5'b11110 || bus.tick !== 5'b10110) begin
            n_fail++;
            $display("FAIL sync_c59: got clk=%b tick=%b exp 11110/10110", bus.clkOut, bus.tick);
        end
        // Sync together with a write: divisor takes effect immediately.
        run_to(60);
        bus.sync = 1'b1; bus.div_wr = 1'b1; bus.div_ch = 3'd2; bus.div_data = 32'd2;
        run_to(61);
        bus.sync = 1'b0; bus.div_wr = 1'b0;
        n_tests++;
        if (bus.pending !== 5'b00000 || bus.clkOut !== 5'b00000) begin
            n_fail++;
            $display("FAIL syncwr_c61: got pend=%b clk=%b exp 00000/00000", bus.pending, bus.clkOut);
        end
        run_to(64);
        n_tests++;
        if (bus.clkOut !== 5'b01100 || bus.tick !== 5'b00100) begin
            n_fail++;
            $display("FAIL syncwr_c64: got clk=%b tick=%b exp 01100/00100", bus.clkOut, bus.tick);
        end
    endtask

    task automatic test_tc_write();
        do_reset();
        run_to(50);
        bus.div_wr = 1'b1; bus.div_ch = 3'd1; bus.div_data = 32'd3;
        run_to(51);
        bus.div_wr = 1'b0;
        n_tests++;
        if (bus.pending !== 5'b00010 || bus.clkOut !== 5'b11111) begin
            n_fail++;
            $display("FAIL tcwr_c51: got pend=%b clk=%b exp 00010/11111", bus.pending, bus.clkOut);
        end
        run_to(102);
        n_tests++;
        if (bus.pending !== 5'b00000 || bus.clkOut !== 5'b00000 || bus.tick !== 5'b11111) begin
            n_fail++;
            $display("FAIL tcwr_c102: got pend=%b clk=%b tick=%b exp 00000/00000/11111", bus.pending, bus.clkOut, bus.tick);
        end
        run_to(106);
        n_tests++;
        if (bus.clkOut[1] !== 1'b1 || bus.tick[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL tcwr_c106: got clk[1]=%b tick[1]=%b exp 1/1", bus.clkOut[1], bus.tick[1]);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        run_to(9);
        bus.div_wr = 1'b1; bus.div_ch = 3'd5; bus.div_data = 32'd5;
        run_to(10);
        bus.div_wr = 1'b0;
        n_tests++;
        if (bus.pending !== 5'b00000) begin
            n_fail++;
            $display("FAIL oor_pend: got %b exp 00000", bus.pending);
        end
        // Two writes to ch4 before its terminal count: the later one (1) wins.
        run_to(19);
        bus.div_wr = 1'b1; bus.div_ch = 3'd4; bus.div_data = 32'd9;
        run_to(20);
        bus.div_data = 32'd1;
        run_to(21);
        bus.div_wr = 1'b0; bus.div_ch = 3'd0;
        n_tests++;
        if (bus.pending !== 5'b10000) begin
            n_fail++;
            $display("FAIL oor_lastwr_pend: got %b exp 10000", bus.pending);
        end
        run_to(51);
        n_tests++;
        if (bus.clkOut !== 5'b11111 || bus.pending !== 5'b00000) begin
            n_fail++;
            $display("FAIL oor_c51: got clk=%b pend=%b exp 11111/00000", bus.clkOut, bus.pending);
        end
        run_to(53);
        n_tests++;
        if (bus.clkOut !== 5'b01111 || bus.tick !== 5'b10000) begin
            n_fail++;
            $display("FAIL oor_c53: got clk=%b tick=%b exp 01111/10000", bus.clkOut, bus.tick);
        end
        run_to(102);
        n_tests++;
        if (bus.clkOut[3:0] !== 4'b0000 || bus.tick[3:0] !== 4'b1111) begin
            n_fail++;
            $display("FAIL oor_c102: got clk=%b tick=%b exp x0000/x1111", bus.clkOut, bus.tick);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_to(9);
        bus.sync = 1'b1; bus.div_wr = 1'b1; bus.div_ch = 3'd0; bus.div_data = 32'd9;
        run_to(10);
        bus.sync = 1'b0; bus.div_wr = 1'b0;
        run_to(25);
        n_tests++;
        if (bus.clkOut !== 5'b00001) begin
            n_fail++;
            $display("FAIL rmid_c25: got clk=%b exp 00001", bus.clkOut);
        end
`ifdef CLK_DIV_READBACK_EN
        n_tests++;
        if (bus.div_rd !== 32'd9) begin
            n_fail++;
            $display("FAIL rmid_div_rd9: got %0d exp 9", bus.div_rd);
        end
`endif
        #3 reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.clkOut, bus.tick, bus.pending} !== 15'h0) begin
            n_fail++;
            $display("FAIL rmid_async: got clk=%b tick=%b pend=%b exp all 0", bus.clkOut, bus.tick, bus.pending);
        end
        @(posedge clkIn); #1;
        reset = 1'b1;
        cyc = 0;
        run_to(50);
        n_tests++;
        if (bus.clkOut !== 5'b00000) begin
            n_fail++;
            $display("FAIL rmid_c50: got clk=%b exp 00000", bus.clkOut);
        end
        run_to(51);
        n_tests++;
        if (bus.clkOut !== 5'b11111 || bus.tick !== 5'b11111) begin
            n_fail++;
            $display("FAIL rmid_c51: got clk=%b tick=%b exp 11111/11111", bus.clkOut, bus.tick);
        end
`ifdef CLK_DIV_READBACK_EN
        n_tests++;
        if (bus.div_rd !== 32'd50) begin
            n_fail++;
            $display("FAIL rmid_div_rd50: got %0d exp 50", bus.div_rd);
        end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        test_reset();
        test_default();
        test_write();
        test_enable();
        test_sync();
        test_tc_write();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
